pico_rom_arbiter: RTL and testbench
===================================

Name: pico_rom_arbiter

Overview:
- Shares the single-port 4096x32 on-chip program/data memory between two PicoRV32-side requesters: instruction fetch (read-only) and data (read/write).
- Sequences each access into the memory's Avalon-style slave: chipselect/write/byteenable/debugaccess, registered address, one-cycle read latency.
- Gates writes with a software unlock and flags denied writes.
- Sits between the CPU memory interface and the memory instance inside pico_qsys.

Parameters:
ADDR_W, 12, word-address width of the memory (4096 words)
DATA_W, 32, data width; byteenable width is DATA_W/8

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
i_valid  in  1  fetch request, held until i_ready
i_addr  in  ADDR_W  fetch word address
i_ready  out  1  one-cycle completion pulse for fetch
i_rdata  out  DATA_W  fetch data, valid when i_ready=1
d_valid  in  1  data request, held until d_ready
d_addr  in  ADDR_W  data word address
d_wstrb  in  4  byte strobes; 0000 = read, non-zero = write
d_wdata  in  DATA_W  write data
d_ready  out  1  one-cycle completion pulse for data
d_rdata  out  DATA_W  read data, valid when d_ready=1
wr_unlock  in  1  1 = memory writes permitted
err_clr  in  1  clears wr_err
wr_err  out  1  sticky: a write was attempted while locked
rom_address  out  ADDR_W  memory address
rom_byteenable  out  4  memory byte enables
rom_chipselect  out  1  memory select
rom_write  out  1  memory write
rom_debugaccess  out  1  memory write qualifier
rom_writedata  out  DATA_W  memory write data
rom_clken  out  1  memory clock enable, tied 1
rom_readdata  in  DATA_W  memory read data, valid the cycle after the address edge

Behaviour:
- Reset, asynchronous on reset_n low:
  - State IDLE; all outputs 0 except rom_clken=1 and rom_byteenable=4'hF.
  - RR pointer = "data last", so fetch wins the first tie.
  - wr_err=0; i_rdata and d_rdata cleared.
- Reset asserted mid-transaction aborts it: no ready pulse is issued, and a pending write is never completed.
- FSM states: IDLE, ACCESS, DATA, RESP.
- IDLE:
  - Sample i_valid and d_valid. If exactly one is high, grant it. If both are high, grant the port not granted last.
  - Register the granted port's address, strobes and wdata; update the RR pointer; go to ACCESS.
- ACCESS (one cycle):
  - rom_chipselect=1 and rom_address = latched address.
  - Read: rom_byteenable=4'hF, rom_write=0, next state DATA.
  - Permitted write (wr_unlock=1): rom_write=1, rom_debugaccess=1, rom_byteenable = latched strobes, next state RESP.
  - Denied write (wr_unlock=0): rom_write=0, rom_debugaccess=0, wr_err set, next state RESP.
- DATA (one cycle): capture rom_readdata into the granted port's rdata register; go to RESP.
- RESP (one cycle): the granted port's ready=1; go to IDLE.
  - Each port's rdata holds its value until that port's next read completes.
  - Writes leave rdata unchanged.
- Latency, counted from the cycle valid is first sampled in IDLE (cycle 0):
  - Read: ready at cycle 3.
  - Write: ready at cycle 2.
  - A back-to-back request is accepted in the IDLE cycle following RESP.
- i-port with a fetch: always treated as a read; the fetch port has no strobes.
- Fairness: under continuous contention grants alternate i, d, i, d, …
- Protocol: a requester dropping valid mid-transaction is illegal. The transaction still completes and the ready pulse is still issued.
- wr_err: a set event and err_clr in the same cycle resolve to set; otherwise err_clr clears it.
- rom_chipselect, rom_write and rom_debugaccess are registered outputs, glitch-free.
- rom_clken is constant 1.

Decomposition:
- Package pico_rom_pkg holds:
  - state enum {IDLE, ACCESS, DATA, RESP};
  - ADDR_W/DATA_W defaults;
  - port-index constants PORT_I=0, PORT_D=1.
- One sub-module, pico_rr_arb2: two-request round-robin with a registered last-grant pointer and an update-enable input.

Test Plan:
- Fetch-only read: i_valid=1, i_addr=0x010, memory word 0x010 = 0x00000013 -> i_ready single pulse at cycle 3, i_rdata=0x00000013, d_ready stays 0.
- Unlocked data write then read: wr_unlock=1, d_addr=0x100, d_wstrb=4'b0011, d_wdata=0xAABBCCDD over old value 0x11223344 -> d_ready at cycle 2; a following read returns 0x1122CCDD.
- Locked write: wr_unlock=0, d_wstrb=4'hF, d_addr=0x200 -> rom_write never 1, d_ready at cycle 2, wr_err=1 and sticky; err_clr pulse clears it to 0.
- Contention: i_valid and d_valid both held high for 4 transactions -> grant order i, d, i, d; each ready pulses exactly once per transaction.
- Reset in ACCESS of a write: reset_n low during the ACCESS cycle -> all outputs return to reset values immediately, no ready pulse; after release a fetch to 0x000 completes normally at cycle 3.
- Wrap-around address: d_addr=0xFFF read -> rom_address=0xFFF, d_rdata = last memory word, no aliasing to 0x000.

Source files
------------

// File: rtl/pico_rom_pkg.sv
// ============================================================
// Module   : pico_rom_pkg
// Purpose  : Shared types and constants for the program-memory arbiter.
// Revision : 1.0 - initial release
// ============================================================
`default_nettype none

package pico_rom_pkg;

   localparam int DEF_ADDR_W = 12;
   localparam int DEF_DATA_W = 32;

   localparam logic PORT_I = 1'b0;
   localparam logic PORT_D = 1'b1;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      DATA   = 2'd2,
      RESP   = 2'd3
   } state_t;

endpackage

`default_nettype wire

// File: rtl/pico_rr_arb2.sv
// ============================================================
// Module   : pico_rr_arb2
// Purpose  : Two-request round-robin arbiter with registered last-grant pointer.
// Revision : 1.0 - initial release
// ============================================================
`default_nettype none

module pico_rr_arb2
   import pico_rom_pkg::*;
(
   input  logic       clk,
   input  logic       reset_n,
   input  logic [1:0] i_req,
   input  logic       i_update,
   output logic       o_grant,
   output logic       o_any
);

   logic r_last;

   always_comb begin
      o_any   = |i_req;
      o_grant = PORT_I;
      if (&i_req)
         o_grant = ~r_last;
      else if (i_req[PORT_D])
         o_grant = PORT_D;
   end

   // Reset to "data last" so the fetch port wins the first tie.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
         r_last <= PORT_D;
      else if (i_update && o_any)
         r_last <= o_grant;
   end

endmodule

`default_nettype wire

// File: rtl/pico_rom_arbiter.sv
// ============================================================
// Module   : pico_rom_arbiter
// Purpose  : Shares the 4096x32 program/data memory between fetch and data ports.
// Revision : 1.0 - initial release
// ============================================================
`default_nettype none

module pico_rom_arbiter
   import pico_rom_pkg::*;
#(
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int DATA_W = DEF_DATA_W
)(
   input  logic                clk,
   input  logic                reset_n,
   input  logic                i_valid,
   input  logic [ADDR_W-1:0]   i_addr,
   output logic                i_ready,
   output logic [DATA_W-1:0]   i_rdata,
   input  logic                d_valid,
   input  logic [ADDR_W-1:0]   d_addr,
   input  logic [DATA_W/8-1:0] d_wstrb,
   input  logic [DATA_W-1:0]   d_wdata,
   output logic                d_ready,
   output logic [DATA_W-1:0]   d_rdata,
   input  logic                wr_unlock,
   input  logic                err_clr,
   output logic                wr_err,
   output logic [ADDR_W-1:0]   rom_address,
   output logic [DATA_W/8-1:0] rom_byteenable,
   output logic                rom_chipselect,
   output logic                rom_write,
   output logic                rom_debugaccess,
   output logic [DATA_W-1:0]   rom_writedata,
   output logic                rom_clken,
   input  logic [DATA_W-1:0]   rom_readdata
);

   localparam int BE_W = DATA_W / 8;

   state_t              r_state;
   state_t              w_next_state;
   logic                r_port;
   logic [ADDR_W-1:0]   r_addr;
   logic [DATA_W-1:0]   r_wdata;
   logic [BE_W-1:0]     r_be;
   logic                r_is_write;
   logic                r_cs;
   logic                r_we;
   logic                r_wr_err;
   logic [DATA_W-1:0]   r_i_rdata;
   logic [DATA_W-1:0]   r_d_rdata;

   logic                w_grant;
   logic                w_any;
   logic                w_accept;
   logic                w_sel_write;
   logic                w_err_set;

   pico_rr_arb2 u_arb (
      .clk      (clk),
      .reset_n  (reset_n),
      .i_req    ({d_valid, i_valid}),
      .i_update (w_accept),
      .o_grant  (w_grant),
      .o_any    (w_any)
   );

   assign w_accept    = (r_state == IDLE) && w_any;
   assign w_sel_write = (w_grant == PORT_D) && (|d_wstrb);
   // A denied write is recognisable in ACCESS as a write whose strobe was never raised.
   assign w_err_set   = (r_state == ACCESS) && r_is_write && !r_we;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
         r_state <= IDLE;
      else
         r_state <= w_next_state;
   end

   always_comb begin
      w_next_state = r_state;
      case (r_state)
         IDLE:    if (w_any) w_next_state = ACCESS;
         ACCESS:  w_next_state = r_is_write ? RESP : DATA;
         DATA:    w_next_state = RESP;
         RESP:    w_next_state = IDLE;
         default: w_next_state = IDLE;
      endcase
   end

   // Memory strobes are launched from registers on the grant edge so they are glitch-free.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_port     <= PORT_I;
         r_addr     <= '0;
         r_wdata    <= '0;
         r_be       <= '1;
         r_is_write <= 1'b0;
         r_cs       <= 1'b0;
         r_we       <= 1'b0;
      end else if (w_accept) begin
         r_port     <= w_grant;
         r_addr     <= (w_grant == PORT_D) ? d_addr : i_addr;
         r_wdata    <= d_wdata;
         r_is_write <= w_sel_write;
         r_cs       <= 1'b1;
         r_we       <= w_sel_write && wr_unlock;
         r_be       <= (w_sel_write && wr_unlock) ? d_wstrb : '1;
      end else if (r_state == ACCESS) begin
         r_cs <= 1'b0;
         r_we <= 1'b0;
         r_be <= '1;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_i_rdata <= '0;
         r_d_rdata <= '0;
      end else if (r_state == DATA) begin
         if (r_port == PORT_D)
            r_d_rdata <= rom_readdata;
         else
            r_i_rdata <= rom_readdata;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
         r_wr_err <= 1'b0;
      else if (w_err_set)
         r_wr_err <= 1'b1;
      else if (err_clr)
         r_wr_err <= 1'b0;
   end

   assign i_ready         = (r_state == RESP) && (r_port == PORT_I);
   assign d_ready         = (r_state == RESP) && (r_port == PORT_D);
   assign i_rdata         = r_i_rdata;
   assign d_rdata         = r_d_rdata;
   assign wr_err          = r_wr_err;
   assign rom_address     = r_addr;
   assign rom_byteenable  = r_be;
   assign rom_chipselect  = r_cs;
   assign rom_write       = r_we;
   assign rom_debugaccess = r_we;
   assign rom_writedata   = r_wdata;
   assign rom_clken       = 1'b1;

endmodule

`default_nettype wire

// File: tb/tb_pico_rom_arbiter.sv
// ============================================================
// Module   : tb_pico_rom_arbiter
// Purpose  : Directed vector bench for pico_rom_arbiter with a synchronous memory model.
// Revision : 1.0 - initial release
// ============================================================
`default_nettype none

module tb_pico_rom_arbiter;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        i_valid, d_valid;
   logic [11:0] i_addr, d_addr;
   logic [3:0]  d_wstrb;
   logic [31:0] d_wdata;
   logic        i_ready, d_ready;
   logic [31:0] i_rdata, d_rdata;
   logic        wr_unlock, err_clr, wr_err;
   logic [11:0] rom_address;
   logic [3:0]  rom_byteenable;
   logic        rom_chipselect, rom_write, rom_debugaccess, rom_clken;
   logic [31:0] rom_writedata;
   logic [31:0] rom_readdata = 32'h0;

   int total = 0;
   int bad   = 0;

   pico_rom_arbiter dut (
      .clk             (clk),
      .reset_n         (reset_n),
      .i_valid         (i_valid),
      .i_addr          (i_addr),
      .i_ready         (i_ready),
      .i_rdata         (i_rdata),
      .d_valid         (d_valid),
      .d_addr          (d_addr),
      .d_wstrb         (d_wstrb),
      .d_wdata         (d_wdata),
      .d_ready         (d_ready),
      .d_rdata         (d_rdata),
      .wr_unlock       (wr_unlock),
      .err_clr         (err_clr),
      .wr_err          (wr_err),
      .rom_address     (rom_address),
      .rom_byteenable  (rom_byteenable),
      .rom_chipselect  (rom_chipselect),
      .rom_write       (rom_write),
      .rom_debugaccess (rom_debugaccess),
      .rom_writedata   (rom_writedata),
      .rom_clken       (rom_clken),
      .rom_readdata    (rom_readdata)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] init_word(input int k);
      case (k)
         'h000:   return 32'h0000_0093;
         'h010:   return 32'h0000_0013;
         'h100:   return 32'h1122_3344;
         'h200:   return 32'h5566_7788;
         'h300:   return 32'h0101_0101;
         'hFFF:   return 32'hDEAD_BEEF;
         default: return 32'hA500_0000 | k;
      endcase
   endfunction

   // Synchronous single-port memory with one-cycle read latency.
   logic [31:0] mem [0:4095];
   bit          mem_inited = 1'b0;
   always @(posedge clk) begin
      if (!mem_inited) begin
         for (int k = 0; k < 4096; k++) mem[k] <= init_word(k);
         mem_inited <= 1'b1;
      end else if (rom_chipselect && rom_clken) begin
         if (rom_write) begin
            for (int b = 0; b < 4; b++)
               if (rom_byteenable[b]) mem[rom_address][8*b +: 8] <= rom_writedata[8*b +: 8];
         end
         rom_readdata <= mem[rom_address];
      end
   end

   int          mon_we = 0, mon_ir = 0, mon_dr = 0, mon_both = 0;
   logic [11:0] mon_cs_addr = '0;
   always @(negedge clk) begin
      if (rom_write) mon_we++;
      if (i_ready) mon_ir++;
      if (d_ready) mon_dr++;
      if (i_ready && d_ready) mon_both++;
      if (rom_chipselect) mon_cs_addr = rom_address;
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   typedef struct {
      logic        is_d;
      logic [11:0] addr;
      logic [3:0]  wstrb;
      logic [31:0] wdata;
      logic        unlock;
      logic [31:0] exp_rdata;
      int          exp_lat;
      logic        exp_err;
   } vec_t;

   logic [31:0] exp_i_rd = '0;
   logic [31:0] exp_d_rd = '0;

   task automatic run_vec(input vec_t v, input string nm);
      int  lat;
      int  we0, ir0, dr0;
      bit  is_wr;
      is_wr = v.is_d && (v.wstrb != 4'h0);
      @(posedge clk); #1;
      wr_unlock = v.unlock;
      if (v.is_d) begin
         d_valid = 1'b1; d_addr = v.addr; d_wstrb = v.wstrb; d_wdata = v.wdata;
      end else begin
         i_valid = 1'b1; i_addr = v.addr;
      end
      we0 = mon_we; ir0 = mon_ir; dr0 = mon_dr;
      if (!is_wr) begin
         if (v.is_d) exp_d_rd = v.exp_rdata;
         else        exp_i_rd = v.exp_rdata;
      end
      lat = 0;
      forever begin
         @(negedge clk);
         if (v.is_d ? d_ready : i_ready) break;
         lat++;
         if (lat > 20) break;
      end
      chk({nm, " latency"}, lat, v.exp_lat);
      chk({nm, " rdata"}, v.is_d ? d_rdata : i_rdata, v.is_d ? exp_d_rd : exp_i_rd);
      chk({nm, " wr_err"}, {31'b0, wr_err}, {31'b0, v.exp_err});
      @(posedge clk); #1;
      i_valid = 1'b0; d_valid = 1'b0;
      @(negedge clk);
      chk({nm, " own ready pulses"}, v.is_d ? mon_dr - dr0 : mon_ir - ir0, 1);
      chk({nm, " other ready pulses"}, v.is_d ? mon_ir - ir0 : mon_dr - dr0, 0);
      chk({nm, " rom_write cycles"}, mon_we - we0, (is_wr && v.unlock) ? 1 : 0);
      if (!is_wr) chk({nm, " rom_address"}, {20'b0, mon_cs_addr}, {20'b0, v.addr});
   endtask

   vec_t vecs [7];
   vec_t v;

   initial begin
      int n;
      int ord [4];
      int ir0, dr0;

      vecs[0] = '{1'b0, 12'h010, 4'h0, 32'h0,          1'b1, 32'h0000_0013, 3, 1'b0};
      vecs[1] = '{1'b1, 12'h100, 4'h3, 32'hAABB_CCDD,  1'b1, 32'h0,         2, 1'b0};
      vecs[2] = '{1'b1, 12'h100, 4'h0, 32'h0,          1'b1, 32'h1122_CCDD, 3, 1'b0};
      vecs[3] = '{1'b1, 12'h200, 4'hF, 32'hFFFF_FFFF,  1'b0, 32'h0,         2, 1'b1};
      vecs[4] = '{1'b1, 12'h200, 4'h0, 32'h0,          1'b0, 32'h5566_7788, 3, 1'b1};
      vecs[5] = '{1'b1, 12'hFFF, 4'h0, 32'h0,          1'b0, 32'hDEAD_BEEF, 3, 1'b1};
      vecs[6] = '{1'b0, 12'hFFF, 4'h0, 32'h0,          1'b0, 32'hDEAD_BEEF, 3, 1'b1};

      reset_n = 1'b0; i_valid = 1'b0; d_valid = 1'b0; i_addr = '0; d_addr = '0;
      d_wstrb = '0; d_wdata = '0; wr_unlock = 1'b0; err_clr = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      chk("reset rom_clken", {31'b0, rom_clken}, 32'h1);
      chk("reset rom_byteenable", {28'b0, rom_byteenable}, 32'hF);
      chk("reset rom_chipselect", {31'b0, rom_chipselect}, 32'h0);
      chk("reset ready", {30'b0, i_ready, d_ready}, 32'h0);
      chk("reset rdata", i_rdata | d_rdata, 32'h0);
      chk("reset wr_err", {31'b0, wr_err}, 32'h0);
      @(negedge clk) reset_n = 1'b1;

      for (int k = 0; k < 7; k++) run_vec(vecs[k], $sformatf("vec%0d", k));

      // err_clr clears the sticky flag
      @(posedge clk); #1 err_clr = 1'b1;
      @(posedge clk); #1 err_clr = 1'b0;
      @(negedge clk);
      chk("err_clr clears", {31'b0, wr_err}, 32'h0);

      // set and clear in the same cycle: set wins, then clear acts
      err_clr = 1'b1;
      v = '{1'b1, 12'h200, 4'hF, 32'h0, 1'b0, 32'h0, 2, 1'b1};
      run_vec(v, "set_vs_clr");
      err_clr = 1'b0;
      chk("set_vs_clr later cleared", {31'b0, wr_err}, 32'h0);

      // continuous contention: i, d, i, d
      @(posedge clk); #1;
      i_addr = 12'h010; d_addr = 12'h100; d_wstrb = 4'h0; i_valid = 1'b1; d_valid = 1'b1;
      ir0 = mon_ir; dr0 = mon_dr;
      n = 0;
      for (int c = 0; c < 60 && n < 4; c++) begin
         @(negedge clk);
         if (i_ready) begin
            ord[n] = 0; n++;
            chk("contention i_rdata", i_rdata, 32'h0000_0013);
         end else if (d_ready) begin
            ord[n] = 1; n++;
            chk("contention d_rdata", d_rdata, 32'h1122_CCDD);
         end
         if (n == 4) begin
            i_valid = 1'b0; d_valid = 1'b0;
         end
      end
      chk("contention count", n, 4);
      if (n == 4) begin
         for (int k = 0; k < 4; k++) chk($sformatf("contention grant%0d", k), ord[k], k % 2);
      end
      @(negedge clk);
      chk("contention i pulses", mon_ir - ir0, 2);
      chk("contention d pulses", mon_dr - dr0, 2);
      chk("never both ready", mon_both, 0);
      exp_d_rd = 32'h1122_CCDD;

      // reset asserted in ACCESS of a permitted write
      @(posedge clk); #1;
      wr_unlock = 1'b1; d_valid = 1'b1; d_addr = 12'h300; d_wstrb = 4'hF; d_wdata = 32'hCAFE_F00D;
      @(posedge clk); #1;
      chk("abort in ACCESS", {31'b0, rom_write}, 32'h1);
      ir0 = mon_ir; dr0 = mon_dr;
      reset_n = 1'b0;
      #1;
      chk("abort rom_write", {31'b0, rom_write}, 32'h0);
      chk("abort rom_chipselect", {31'b0, rom_chipselect}, 32'h0);
      chk("abort rom_byteenable", {28'b0, rom_byteenable}, 32'hF);
      chk("abort d_rdata", d_rdata, 32'h0);
      repeat (2) @(posedge clk);
      #1 d_valid = 1'b0; d_wstrb = 4'h0;
      @(negedge clk) reset_n = 1'b1;
      chk("abort no ready", (mon_ir - ir0) + (mon_dr - dr0), 0);
      exp_i_rd = '0; exp_d_rd = '0;
      v = '{1'b0, 12'h000, 4'h0, 32'h0, 1'b1, 32'h0000_0093, 3, 1'b0};
      run_vec(v, "post_reset fetch");
      v = '{1'b1, 12'h300, 4'h0, 32'h0, 1'b1, 32'h0101_0101, 3, 1'b0};
      run_vec(v, "aborted write untouched");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire
